// File: rtl/sar_search.sv
// Successive-approximation search over [0, 2^WIDTH-1] driven by an external comparator.
// Optional macro SAR_SEARCH_XCHECK_EN aborts a search on X/Z comparator inputs and flags error.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             cmp_valid,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] TOP = {1'b0, {WIDTH{1'b1}}};

  state_t           state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH:0]   g_inc;
  logic [WIDTH:0]   g_dec;

  // Bounds are kept with a spare bit so lo+((hi-lo)>>1) can never wrap.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] l, input logic [WIDTH:0] h);
    return WIDTH'(l + ((h - l) >> 1));
  endfunction

  assign g_inc = {1'b0, guess} + ONE;
  assign g_dec = {1'b0, guess} - ONE;

`ifdef SAR_SEARCH_XCHECK_EN
  logic err_q;
  logic cmp_unknown;
  // x^x stays x, so any X/Z on either comparator bit makes this case-inequality true.
  assign cmp_unknown = (({cmp_eq, cmp_gt} ^ {cmp_eq, cmp_gt}) !== 2'b00);
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      result <= '0;
`ifdef SAR_SEARCH_XCHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lo     <= '0;
            hi     <= '1;
            guess  <= midpoint('0, TOP);
            found  <= 1'b0;
            result <= '0;
`ifdef SAR_SEARCH_XCHECK_EN
            err_q  <= 1'b0;
`endif
            busy   <= 1'b1;
            state  <= PROBE;
          end
        end
        PROBE: begin
          if (cmp_valid) begin
`ifdef SAR_SEARCH_XCHECK_EN
            if (cmp_unknown) begin
              err_q  <= 1'b1;
              found  <= 1'b0;
              result <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else
`endif
            if (cmp_eq) begin
              found  <= 1'b1;
              result <= guess;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else if (cmp_gt) begin
              if (guess == hi) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                lo    <= WIDTH'(g_inc);
                guess <= midpoint(g_inc, {1'b0, hi});
              end
            end else begin
              if (guess == lo) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                hi    <= WIDTH'(g_dec);
                guess <= midpoint({1'b0, lo}, g_dec);
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed and randomized searches against an integer
// binary-search reference model, plus reset, idle-ignore and X-check scenarios.
module tb_sar_search;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         cmp_valid = 1'b0;
  logic         cmp_eq = 1'b0;
  logic         cmp_gt = 1'b0;
  logic [W-1:0] guess;
  logic         busy;
  logic         done;
  logic         found;
  logic [W-1:0] result;
  logic         error;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit exp_found;
  int exp_result;

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .guess(guess),
    .cmp_valid(cmp_valid), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .busy(busy), .done(done), .found(found), .result(result), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: honest comparator for target t; mode 1: always "less"; mode 2: always "greater"
  function automatic void answer(input int mode, input int t, input int g, output bit eq, output bit gt);
    case (mode)
      0:       begin eq = (g == t); gt = (t > g); end
      1:       begin eq = 1'b0;     gt = 1'b0;    end
      default: begin eq = 1'b0;     gt = 1'b1;    end
    endcase
  endfunction

  // Integer binary search over the candidate range, recording each probe.
  task automatic model(input int mode, input int t);
    int lo, hi, g;
    bit eq, gt;
    exp_q.delete();
    exp_found  = 1'b0;
    exp_result = 0;
    lo = 0;
    hi = MAXV;
    for (int n = 0; n < 64; n++) begin
      g = lo + (hi - lo) / 2;
      exp_q.push_back(g);
      answer(mode, t, g, eq, gt);
      if (eq) begin
        exp_found  = 1'b1;
        exp_result = g;
        break;
      end else if (gt) begin
        if (g == hi) break;
        lo = g + 1;
      end else begin
        if (g == lo) break;
        hi = g - 1;
      end
    end
  endtask

  task automatic run_search(input int mode, input int t, input string name);
    bit eq, gt;
    int stall;
    logic [W-1:0] eg;
    logic [W-1:0] er;
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[i]) begin
      eg = exp_q[i][W-1:0];
      stall = $urandom_range(0, 2);
      for (int s = 0; s <= stall; s++) begin
        checks++;
        if (guess !== eg || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s probe%0d: guess=%0d busy=%b done=%b, required guess=%0d busy=1 done=0",
                   name, i, guess, busy, done, eg);
        end
        if (s < stall) begin
          cmp_valid = 1'b0;
          cmp_eq    = 1'($urandom);
          cmp_gt    = 1'($urandom);
          start     = 1'($urandom);
          tick();
        end
      end
      start = 1'b0;
      answer(mode, t, int'(guess), eq, gt);
      cmp_valid = 1'b1;
      cmp_eq    = eq;
      cmp_gt    = gt;
      tick();
      cmp_valid = 1'b0;
      cmp_eq    = 1'b0;
      cmp_gt    = 1'b0;
    end
    er = exp_result[W-1:0];
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || found !== exp_found || result !== er || error !== 1'b0) begin
      errors++;
      $display("FAIL %s end: done=%b busy=%b found=%b result=%0d error=%b, required 1 0 %b %0d 0",
               name, done, busy, found, result, error, exp_found, er);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || found !== exp_found || result !== er) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b found=%b result=%0d, required 0 0 %b %0d",
               name, done, busy, found, result, exp_found, er);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cmp_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0; start = 1'b0; cmp_valid = 1'b0;
    checks++;
    if ({guess, busy, done, found, result, error} !== '0) begin
      errors++;
      $display("FAIL reset: guess=%0d busy=%b done=%b found=%b result=%0d error=%b, required all 0",
               guess, busy, done, found, result, error);
    end
  endtask

  task automatic test_directed();
    exp_q = '{7, 3, 5, 4};      exp_found = 1'b1; exp_result = 4;  run_search(0, 4, "target4");
    exp_q = '{7, 11, 13, 14, 15}; exp_found = 1'b1; exp_result = 15; run_search(0, 15, "target15");
    exp_q = '{7, 3, 1, 0};      exp_found = 1'b1; exp_result = 0;  run_search(0, 0, "target0");
    exp_q = '{7, 3, 1, 0};      exp_found = 1'b0; exp_result = 0;  run_search(1, 0, "always_lt");
    exp_q = '{7, 11, 13, 14, 15}; exp_found = 1'b0; exp_result = 0; run_search(2, 0, "always_gt");
  endtask

  task automatic test_idle_ignore();
    logic [W-1:0] g0;
    g0 = guess;
    cmp_valid = 1'b1; cmp_eq = 1'b1;
    tick();
    tick();
    cmp_valid = 1'b0; cmp_eq = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || guess !== g0 || found !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: busy=%b done=%b guess=%0d found=%b, required 0 0 %0d 0",
               busy, done, guess, found, g0);
    end
  endtask

  task automatic test_random();
    int mode, t;
    for (int k = 0; k < 30; k++) begin
      mode = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      t = $urandom_range(0, MAXV);
      model(mode, t);
      run_search(mode, t, "random");
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_reset_in_probe();
    start = 1'b1;
    tick();
    start = 1'b0;
    cmp_valid = 1'b1; cmp_eq = 1'b0; cmp_gt = 1'b0;
    tick();
    cmp_valid = 1'b0;
    checks++;
    if (guess !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_probe pre: guess=%0d busy=%b, required 3 1", guess, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || guess !== '0 || done !== 1'b0 || found !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL rst_probe: busy=%b guess=%0d done=%b found=%b error=%b, required 0 0 0 0 0",
               busy, guess, done, found, error);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_probe idle: done=%b busy=%b, required 0 0", done, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (guess !== 4'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_probe restart: guess=%0d busy=%b, required 7 1", guess, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_xcheck();
    start = 1'b1;
    tick();
    start = 1'b0;
    cmp_valid = 1'b1; cmp_eq = 1'bx; cmp_gt = 1'b0;
    tick();
    cmp_valid = 1'b0; cmp_eq = 1'b0;
    checks++;
`ifdef SAR_SEARCH_XCHECK_EN
    if (done !== 1'b1 || error !== 1'b1 || found !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL xcheck: done=%b error=%b found=%b result=%0d, required 1 1 0 0",
               done, error, found, result);
    end
`else
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL xcheck: error=%b, required 0", error);
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_directed();
    test_random();
    test_reset_in_probe();
    test_xcheck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
